// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared sfix11_En3 output format constants and round/saturate helper
package filter_pkg;

  localparam int OUT_W    = 11;
  localparam int OUT_FRAC = 3;
  localparam int NPHASE   = 3;
  localparam int SAT_MAX  = 1023;
  localparam int SAT_MIN  = -1024;

  typedef struct packed {
    logic signed [OUT_W-1:0] value;
    logic                    sat;
  } q_result_t;

  // x is a sign-extended sample with (sh+3) fractional bits; rounding is half-up
  function automatic q_result_t round_sat_sfix11(input logic signed [31:0] x, input int sh);
    logic signed [31:0] t;
    q_result_t          r;
    t = (x + (32'sd1 <<< (sh - 1))) >>> sh;
    if (t > SAT_MAX) begin
      r.value = OUT_W'(SAT_MAX);
      r.sat   = 1'b1;
    end else if (t < SAT_MIN) begin
      r.value = OUT_W'(SAT_MIN);
      r.sat   = 1'b1;
    end else begin
      r.value = t[OUT_W-1:0];
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/quant_sfix11_en3.sv
// rtl/quant_sfix11_en3.sv - combinational round-half-up and saturate to sfix11_En3
module quant_sfix11_en3
  import filter_pkg::*;
#(
  parameter int DIN_W    = 16,
  parameter int DIN_FRAC = 8
) (
  input  logic signed [DIN_W-1:0] din,
  output logic signed [OUT_W-1:0] q,
  output logic                    sat_hit
);

  localparam int SH = DIN_FRAC - OUT_FRAC;

  logic signed [31:0] din_ext;
  q_result_t          res;

  assign din_ext = {{(32 - DIN_W){din[DIN_W-1]}}, din};

  always_comb begin
    res = round_sat_sfix11(din_ext, SH);
  end

  assign q       = res.value;
  assign sat_hit = res.sat;

endmodule

// File: rtl/polyphase_input_stage.sv
// rtl/polyphase_input_stage.sv - quantizes base-rate samples and packs them into 3-phase frames
module polyphase_input_stage
  import filter_pkg::*;
#(
  parameter int DIN_W    = 16,
  parameter int DIN_FRAC = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic signed [DIN_W-1:0] din,
  input  logic                    din_valid,
  input  logic                    sync_clear,
  output logic signed [OUT_W-1:0] out_ph0,
  output logic signed [OUT_W-1:0] out_ph1,
  output logic signed [OUT_W-1:0] out_ph2,
  output logic                    enb_1_3_0,
  output logic [1:0]              phase,
  output logic                    sat_flag
);

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;

  logic signed [OUT_W-1:0] q;
  logic                    sat_hit;
  logic                    accept;
  logic signed [OUT_W-1:0] s0;
  logic signed [OUT_W-1:0] s1;

  quant_sfix11_en3 #(
    .DIN_W   (DIN_W),
    .DIN_FRAC(DIN_FRAC)
  ) u_quant (
    .din    (din),
    .q      (q),
    .sat_hit(sat_hit)
  );

  assign accept = din_valid & clk_enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0        <= '0;
      s1        <= '0;
      out_ph0   <= '0;
      out_ph1   <= '0;
      out_ph2   <= '0;
      enb_1_3_0 <= 1'b0;
      phase     <= PH_0;
      sat_flag  <= 1'b0;
    end else begin
      enb_1_3_0 <= 1'b0;
      if (sync_clear) begin
        // A sample arriving with the resync becomes the first of the new frame
        s1       <= '0;
        sat_flag <= accept & sat_hit;
        if (accept) begin
          s0    <= q;
          phase <= PH_1;
        end else begin
          s0    <= '0;
          phase <= PH_0;
        end
      end else if (accept) begin
        if (sat_hit) begin
          sat_flag <= 1'b1;
        end
        case (phase)
          PH_0: begin
            s0    <= q;
            phase <= PH_1;
          end
          PH_1: begin
            s1    <= q;
            phase <= PH_2;
          end
          PH_2: begin
            out_ph0   <= s0;
            out_ph1   <= s1;
            out_ph2   <= q;
            enb_1_3_0 <= 1'b1;
            phase     <= PH_0;
          end
          default: phase <= PH_0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_polyphase_input_stage.sv
// tb/tb_polyphase_input_stage.sv - directed bench with reference model and frame scoreboard
module tb_polyphase_input_stage;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_enable;
  logic signed [15:0] din;
  logic               din_valid;
  logic               sync_clear;
  logic signed [10:0] out_ph0;
  logic signed [10:0] out_ph1;
  logic signed [10:0] out_ph2;
  logic               enb_1_3_0;
  logic [1:0]         phase;
  logic               sat_flag;

  typedef struct {
    int a;
    int b;
    int c;
  } frame_t;

  frame_t sb[$];
  int     n_assert = 0;
  int     n_fail   = 0;
  int     n_strobe = 0;

  int m_phase, m_s0, m_s1, m_o0, m_o1, m_o2;
  bit m_sat, m_enb;

  polyphase_input_stage #(
    .DIN_W   (16),
    .DIN_FRAC(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .din       (din),
    .din_valid (din_valid),
    .sync_clear(sync_clear),
    .out_ph0   (out_ph0),
    .out_ph1   (out_ph1),
    .out_ph2   (out_ph2),
    .enb_1_3_0 (enb_1_3_0),
    .phase     (phase),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: real-valued round-half-up of din/32, then clip to 11-bit signed
  function automatic int qref(input logic signed [15:0] d, output bit hit);
    real r;
    int  v;
    r   = $floor($itor(d) / 32.0 + 0.5);
    v   = $rtoi(r);
    hit = 1'b0;
    if (v > 1023) begin
      v   = 1023;
      hit = 1'b1;
    end else if (v < -1024) begin
      v   = -1024;
      hit = 1'b1;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_s0 = 0; m_s1 = 0;
    m_o0 = 0; m_o1 = 0; m_o2 = 0;
    m_sat = 1'b0; m_enb = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".enb"}, {31'd0, enb_1_3_0}, {31'd0, m_enb});
    chk({tag, ".phase"}, {30'd0, phase}, m_phase);
    chk({tag, ".sat"}, {31'd0, sat_flag}, {31'd0, m_sat});
    chk({tag, ".ph0"}, $signed(out_ph0), m_o0);
    chk({tag, ".ph1"}, $signed(out_ph1), m_o1);
    chk({tag, ".ph2"}, $signed(out_ph2), m_o2);
  endtask

  task automatic step(input string tag, input logic [15:0] d, input bit v, input bit en, input bit sc);
    bit     acc, hit;
    int     qv;
    frame_t f;
    din = d; din_valid = v; clk_enable = en; sync_clear = sc;
    @(posedge clk);
    acc   = v & en;
    qv    = qref(d, hit);
    m_enb = 1'b0;
    if (sc) begin
      m_s1  = 0;
      m_sat = acc & hit;
      if (acc) begin m_s0 = qv; m_phase = 1; end
      else begin m_s0 = 0; m_phase = 0; end
    end else if (acc) begin
      if (hit) m_sat = 1'b1;
      if (m_phase == 0) begin m_s0 = qv; m_phase = 1; end
      else if (m_phase == 1) begin m_s1 = qv; m_phase = 2; end
      else begin
        m_o0 = m_s0; m_o1 = m_s1; m_o2 = qv;
        m_phase = 0; m_enb = 1'b1;
        f.a = m_s0; f.b = m_s1; f.c = qv;
        sb.push_back(f);
      end
    end
    #1;
    check_state(tag);
    if (enb_1_3_0 === 1'b1) begin
      n_strobe++;
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'sd1, 32'sd0);
      end else begin
        f = sb.pop_front();
        chk({tag, ".sb0"}, $signed(out_ph0), f.a);
        chk({tag, ".sb1"}, $signed(out_ph1), f.b);
        chk({tag, ".sb2"}, $signed(out_ph2), f.c);
      end
    end
    din_valid = 1'b0; sync_clear = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    step(tag, a, 1, 1, 0);
    step(tag, b, 1, 1, 0);
    step(tag, c, 1, 1, 0);
  endtask

  initial begin
    reset = 1'b0; clk_enable = 1'b1; din = '0; din_valid = 1'b1; sync_clear = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      din = 16'($urandom);
      @(posedge clk);
      #1;
      check_state("rst_hold");
    end
    din_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step("idle", 16'h1234, 0, 1, 0);

    n_strobe = 0;
    frame("frame", 16'h0100, 16'h0200, 16'hFF00);
    chk("frame.out0", $signed(out_ph0), 8);
    chk("frame.out1", $signed(out_ph1), 16);
    chk("frame.out2", $signed(out_ph2), -8);
    chk("frame.enb", {31'd0, enb_1_3_0}, 1);
    step("frame_after", 16'h0, 0, 1, 0);
    chk("frame.enb_drop", {31'd0, enb_1_3_0}, 0);
    chk("frame.hold2", $signed(out_ph2), -8);

    frame("rnd_p5", 16'h0000, 16'h0000, 16'h0010);
    chk("rnd_p5.out", $signed(out_ph2), 1);
    frame("rnd_lt", 16'h0000, 16'h0000, 16'h000F);
    chk("rnd_lt.out", $signed(out_ph2), 0);
    frame("rnd_m5", 16'h0000, 16'h0000, 16'hFFF0);
    chk("rnd_m5.out", $signed(out_ph2), 0);
    frame("rnd_m", 16'h0000, 16'h0000, 16'hFFEF);
    chk("rnd_m.out", $signed(out_ph2), -1);

    frame("sat_hi", 16'h0000, 16'h0000, 16'h7FFF);
    chk("sat_hi.out", $signed(out_ph2), 1023);
    chk("sat_hi.flag", {31'd0, sat_flag}, 1);
    frame("sat_lo", 16'h8000, 16'h0040, 16'h0000);
    chk("sat_lo.out", $signed(out_ph0), -1024);
    chk("sat_lo.flag", {31'd0, sat_flag}, 1);
    step("sat_clr", 16'h0, 0, 1, 1);
    chk("sat_clr.flag", {31'd0, sat_flag}, 0);

    n_strobe = 0;
    step("gap", 16'h0300, 1, 1, 0);
    step("gap", 16'h7000, 0, 1, 0);
    step("gap", 16'h7000, 1, 0, 0);
    step("gap", 16'h0400, 1, 1, 0);
    step("gap", 16'h7000, 0, 0, 0);
    step("gap", 16'h7000, 1, 0, 0);
    step("gap", 16'hFE00, 1, 1, 0);
    step("gap", 16'h0000, 0, 1, 0);
    chk("gap.strobes", n_strobe, 1);
    chk("gap.out0", $signed(out_ph0), 24);
    chk("gap.out1", $signed(out_ph1), 32);
    chk("gap.out2", $signed(out_ph2), -16);

    n_strobe = 0;
    step("resync", 16'h0A00, 1, 1, 0);
    step("resync", 16'h0B00, 1, 1, 0);
    step("resync", 16'h0C00, 1, 1, 1);
    chk("resync.enb_c", {31'd0, enb_1_3_0}, 0);
    step("resync", 16'h0D00, 1, 1, 0);
    step("resync", 16'h0E00, 1, 1, 0);
    chk("resync.strobes", n_strobe, 1);
    chk("resync.out0", $signed(out_ph0), 96);
    chk("resync.out1", $signed(out_ph1), 104);
    chk("resync.out2", $signed(out_ph2), 112);

    n_strobe = 0;
    step("rst_mid", 16'h0100, 1, 1, 0);
    step("rst_mid", 16'h0200, 1, 1, 0);
    reset = 1'b0;
    #2;
    model_reset();
    check_state("rst_mid_async");
    reset = 1'b1;
    step("rst_mid", 16'h0500, 1, 1, 0);
    step("rst_mid", 16'h0600, 1, 1, 0);
    step("rst_mid", 16'h0700, 1, 1, 0);
    chk("rst_mid.strobes", n_strobe, 1);
    chk("rst_mid.out0", $signed(out_ph0), 40);
    chk("rst_mid.out2", $signed(out_ph2), 56);
    step("tail", 16'h0, 0, 1, 0);

    chk("sb.leftover", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/polyphase_input_stage.md
Name: polyphase_input_stage

Overview:
- Upstream feeder of the 3-phase FIR section.
- Accepts a base-rate sample stream in sfix16_En8 and quantizes each sample to sfix11_En3 (round, saturate).
- Collects three consecutive samples into one polyphase frame.
- Presents the frame on three phase outputs and generates the 1/3-rate enable pulse that clocks the FIR section's delay lines.

Parameters:
- DIN_W, 16, input sample width (signed).
- DIN_FRAC, 8, input fractional bits. Must satisfy DIN_FRAC >= 4, because quantization shift = DIN_FRAC-3.
- Output format is fixed at sfix11_En3 and is not parameterized.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous reset, active-low. All state clears while reset==0.
- clk_enable  in  1  base-rate enable. No sample is accepted while low.
- din  in  DIN_W  input sample, signed, sfix16_En8 at default.
- din_valid  in  1  sample present. A sample is accepted when din_valid & clk_enable.
- sync_clear  in  1  frame resynchronization (see Behaviour).
- out_ph0  out  11  sfix11_En3, first sample of frame; drives FIR In1.
- out_ph1  out  11  sfix11_En3, second sample of frame; drives FIR In2.
- out_ph2  out  11  sfix11_En3, third sample of frame; drives FIR In3.
- enb_1_3_0  out  1  one-cycle frame strobe; drives FIR enb_1_3_0.
- phase  out  2  current fill count, 0..2.
- sat_flag  out  1  sticky saturation indicator.

Behaviour:
- Reset (reset==0, asynchronous):
  - out_ph0/1/2 = 0, enb_1_3_0 = 0, phase = 0, sat_flag = 0.
  - Staging registers s0, s1 = 0.
- Quantizer (combinational on din):
  - Compute t = (din + 2^(SH-1)) >>> SH, where SH = DIN_FRAC-3.
  - Evaluate at DIN_W+1 bits. This is round-half-up: ties round toward +inf.
  - Then saturate t to [-1024, 1023]. sat_hit = 1 when clipping occurs.
- Phase counter, on each accepted sample:
  - phase==0: s0 <= q, phase <= 1.
  - phase==1: s1 <= q, phase <= 2.
  - phase==2: out_ph0 <= s0, out_ph1 <= s1, out_ph2 <= q, phase <= 0, enb_1_3_0 <= 1.
  - No accept: phase and staging hold.
- enb_1_3_0:
  - Registered. High for exactly one clk cycle, in the cycle after the edge that accepted the third sample.
  - Outputs are already updated and stable during that high cycle.
  - Otherwise 0.
  - Minimum spacing between strobes is 3 cycles.
  - The strobe is not gated by clk_enable after it is issued.
- Latency: third sample accepted at edge N → new frame and strobe visible after edge N; strobe drops after edge N+1.
- Outputs out_ph* hold their value between frames.
- sync_clear (synchronous, highest priority after reset):
  - Sets phase to 0 and clears s0, s1. Does not alter out_ph*.
  - Suppresses any strobe that would otherwise be generated that cycle.
  - If a sample is accepted in the same cycle, that sample is stored as s0 and phase becomes 1, i.e. it starts the new frame.
- sat_flag:
  - Set on any accepted sample with sat_hit.
  - Cleared only by reset or sync_clear. Set wins when both occur in the same cycle.
- Reset asserted mid-frame discards the partial frame. The first accepted sample after release is phase 0.

Decomposition:
- Shared package filter_pkg holds:
  - localparams OUT_W=11, OUT_FRAC=3, NPHASE=3.
  - SAT_MAX=1023, SAT_MIN=-1024.
  - A function for round-and-saturate to sfix11_En3, reused by later stages.
- One sub-module is natural: quant_sfix11_en3, a combinational round/saturate that outputs the value and sat_hit. The phase counter, staging and output registers stay in the top level.

Test Plan:
- Reset: hold reset=0 with din toggling → all outputs 0. After release, with no valid, enb_1_3_0 stays 0.
- Frame: din = 0x0100, 0x0200, 0xFF00 on consecutive cycles, valid, clk_enable=1 → one cycle after the third: out_ph0=8, out_ph1=16, out_ph2=-8, enb high for 1 cycle, phase=0.
- Rounding:
  - din 0x0010 → 1; 0x000F → 0.
  - 0xFFF0 → 0; 0xFFEF → -1.
  - Feed each as phase 2 of a frame.
- Saturation:
  - din 0x7FFF → out 1023, sat_flag=1 and stays 1 over later frames.
  - din 0x8000 → -1024 with sat_flag unchanged.
  - sync_clear clears sat_flag.
- Gaps: three valid samples separated by cycles with din_valid=0, and by cycles with clk_enable=0 → exactly one strobe, after the third accept. Frame contents are correct.
- Resync: accept A, B; then assert sync_clear together with valid C; then accept D, E → no strobe at C; the next frame is (C, D, E). Repeat with reset pulsed mid-frame → the partial frame is discarded.
